// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared opcode encodings and instruction-class helpers for the dispatch queue.
// Opcodes are the decoder's compact 7-bit numbering, lui = 1 through andd = 37.
// Helpers classify an opcode by:
//   - issue target (load/store buffer vs reservation station)
//   - which source registers it reads
//   - whether it renames a destination register
package dispatch_pkg;

  localparam logic [6:0] lui   = 7'd1;
  localparam logic [6:0] auipc = 7'd2;
  localparam logic [6:0] jal   = 7'd3;
  localparam logic [6:0] jalr  = 7'd4;
  localparam logic [6:0] beq   = 7'd5;
  localparam logic [6:0] bne   = 7'd6;
  localparam logic [6:0] blt   = 7'd7;
  localparam logic [6:0] bge   = 7'd8;
  localparam logic [6:0] bltu  = 7'd9;
  localparam logic [6:0] bgeu  = 7'd10;
  localparam logic [6:0] lb    = 7'd11;
  localparam logic [6:0] lh    = 7'd12;
  localparam logic [6:0] lw    = 7'd13;
  localparam logic [6:0] lbu   = 7'd14;
  localparam logic [6:0] lhu   = 7'd15;
  localparam logic [6:0] sb    = 7'd16;
  localparam logic [6:0] sh    = 7'd17;
  localparam logic [6:0] sw    = 7'd18;
  localparam logic [6:0] addi  = 7'd19;
  localparam logic [6:0] slti  = 7'd20;
  localparam logic [6:0] sltiu = 7'd21;
  localparam logic [6:0] xori  = 7'd22;
  localparam logic [6:0] ori   = 7'd23;
  localparam logic [6:0] andi  = 7'd24;
  localparam logic [6:0] slli  = 7'd25;
  localparam logic [6:0] srli  = 7'd26;
  localparam logic [6:0] srai  = 7'd27;
  localparam logic [6:0] add   = 7'd28;
  localparam logic [6:0] sub   = 7'd29;
  localparam logic [6:0] sll   = 7'd30;
  localparam logic [6:0] slt   = 7'd31;
  localparam logic [6:0] sltu  = 7'd32;
  localparam logic [6:0] xorr  = 7'd33;
  localparam logic [6:0] srl   = 7'd34;
  localparam logic [6:0] sra   = 7'd35;
  localparam logic [6:0] orr   = 7'd36;
  localparam logic [6:0] andd  = 7'd37;

  // Register-number encoding meaning "no register" (bit 5 set).
  localparam logic [5:0] NON_REG = 6'b100000;

  typedef enum logic {TGT_RS, TGT_LSB} issue_target_e;

  function automatic logic is_ls(input logic [6:0] op);
    return op inside {[lb:sw]};
  endfunction

  function automatic logic has_rs1(input logic [6:0] op);
    return !(op inside {lui, auipc, jal});
  endfunction

  function automatic logic has_rs2(input logic [6:0] op);
    return op inside {[beq:bgeu], [sb:sw], [add:andd]};
  endfunction

  // Branches and stores produce no register result.
  function automatic logic writes_rd(input logic [6:0] op);
    return !(op inside {[beq:bgeu], [sb:sw]});
  endfunction

  function automatic issue_target_e target_of(input logic [6:0] op);
    return is_ls(op) ? TGT_LSB : TGT_RS;
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if
// Bundles every dispatcher-facing bus into one interface. The buses are:
//   - decoder push handshake and decoded fields (DCDP_*, DCDP_ready)
//   - register-file source lookup and rename (DPRF_*, RFDP_*)
//   - reorder-buffer query, allocate and flush (DPRoB_*, RoBDP_*)
//   - common-data-bus snoop channels (CDBDP_*)
//   - reservation-station and load/store-buffer issue (DPRS_*, DPLSB_*, *DP_full)
// Modports:
//   - master is the dispatcher view.
//   - slave is the view of the surrounding pipeline.
interface dispatch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 3,
  parameter int NUM_CDB    = 2
);
  localparam int EX_ROB_WIDTH = ROB_WIDTH + 1;

  logic                          RoBDP_flush;

  logic                          DCDP_valid;
  logic                          DCDP_ready;
  logic [ADDR_WIDTH-1:0]         DCDP_pc;
  logic [6:0]                    DCDP_opcode;
  logic [4:0]                    DCDP_rs1;
  logic [4:0]                    DCDP_rs2;
  logic [4:0]                    DCDP_rd;
  logic [31:0]                   DCDP_imm;
  logic                          DCDP_predict;

  logic [5:0]                    DPRF_rs1;
  logic [5:0]                    DPRF_rs2;
  logic [EX_ROB_WIDTH-1:0]       RFDP_Qj;
  logic [EX_ROB_WIDTH-1:0]       RFDP_Qk;
  logic [31:0]                   RFDP_Vj;
  logic [31:0]                   RFDP_Vk;
  logic                          DPRF_en;
  logic [5:0]                    DPRF_rd;
  logic [ROB_WIDTH-1:0]          DPRF_RoB_index;

  logic                          RoBDP_full;
  logic [ROB_WIDTH-1:0]          RoBDP_RoB_index;
  logic [EX_ROB_WIDTH-1:0]       DPRoB_Qj;
  logic [EX_ROB_WIDTH-1:0]       DPRoB_Qk;
  logic                          RoBDP_Qj_ready;
  logic                          RoBDP_Qk_ready;
  logic [31:0]                   RoBDP_Vj;
  logic [31:0]                   RoBDP_Vk;
  logic                          DPRoB_en;
  logic [ADDR_WIDTH-1:0]         DPRoB_pc;
  logic [6:0]                    DPRoB_opcode;
  logic [5:0]                    DPRoB_rd;
  logic                          DPRoB_predict;

  logic [NUM_CDB-1:0]            CDBDP_en;
  logic [NUM_CDB*ROB_WIDTH-1:0]  CDBDP_RoB_index;
  logic [NUM_CDB*32-1:0]         CDBDP_value;

  logic                          RSDP_full;
  logic                          LSBDP_full;

  logic                          DPRS_en;
  logic [ADDR_WIDTH-1:0]         DPRS_pc;
  logic [EX_ROB_WIDTH-1:0]       DPRS_Qj;
  logic [EX_ROB_WIDTH-1:0]       DPRS_Qk;
  logic [31:0]                   DPRS_Vj;
  logic [31:0]                   DPRS_Vk;
  logic [31:0]                   DPRS_imm;
  logic [6:0]                    DPRS_opcode;
  logic [ROB_WIDTH-1:0]          DPRS_RoB_index;

  logic                          DPLSB_en;
  logic [EX_ROB_WIDTH-1:0]       DPLSB_Qj;
  logic [EX_ROB_WIDTH-1:0]       DPLSB_Qk;
  logic [31:0]                   DPLSB_Vj;
  logic [31:0]                   DPLSB_Vk;
  logic [31:0]                   DPLSB_imm;
  logic [6:0]                    DPLSB_opcode;
  logic [ROB_WIDTH-1:0]          DPLSB_RoB_index;

  modport master (
    input  RoBDP_flush,
    input  DCDP_valid, DCDP_pc, DCDP_opcode, DCDP_rs1, DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_predict,
    output DCDP_ready,
    output DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
    input  RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk,
    input  RoBDP_full, RoBDP_RoB_index, RoBDP_Qj_ready, RoBDP_Qk_ready, RoBDP_Vj, RoBDP_Vk,
    output DPRoB_Qj, DPRoB_Qk, DPRoB_en, DPRoB_pc, DPRoB_opcode, DPRoB_rd, DPRoB_predict,
    input  CDBDP_en, CDBDP_RoB_index, CDBDP_value,
    input  RSDP_full, LSBDP_full,
    output DPRS_en, DPRS_pc, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm, DPRS_opcode, DPRS_RoB_index,
    output DPLSB_en, DPLSB_Qj, DPLSB_Qk, DPLSB_Vj, DPLSB_Vk, DPLSB_imm, DPLSB_opcode, DPLSB_RoB_index
  );

  modport slave (
    output RoBDP_flush,
    output DCDP_valid, DCDP_pc, DCDP_opcode, DCDP_rs1, DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_predict,
    input  DCDP_ready,
    input  DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
    output RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk,
    output RoBDP_full, RoBDP_RoB_index, RoBDP_Qj_ready, RoBDP_Qk_ready, RoBDP_Vj, RoBDP_Vk,
    input  DPRoB_Qj, DPRoB_Qk, DPRoB_en, DPRoB_pc, DPRoB_opcode, DPRoB_rd, DPRoB_predict,
    output CDBDP_en, CDBDP_RoB_index, CDBDP_value,
    output RSDP_full, LSBDP_full,
    input  DPRS_en, DPRS_pc, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm, DPRS_opcode, DPRS_RoB_index,
    input  DPLSB_en, DPLSB_Qj, DPLSB_Qk, DPLSB_Vj, DPLSB_Vk, DPLSB_imm, DPLSB_opcode, DPLSB_RoB_index
  );

endinterface

// File: rtl/operand_resolver.sv
// operand_resolver
// Resolves one source operand of the queue head. Sources are tried in
// priority order:
//   1. register file
//   2. reorder-buffer ready value
//   3. lowest-numbered matching common-data-bus channel
// Purely combinational.
// Ports:
//   rf_q/rf_v      tag and value from the register file
//   rob_ready/rob_v  reorder-buffer readiness and value for rf_q
//   cdb_en/cdb_tag/cdb_value  flattened CDB channels (channel i at slice i)
//   q/v            resolved tag (NON_DEP when a value is available) and value
module operand_resolver #(
  parameter int ROB_WIDTH = 3,
  parameter int NUM_CDB   = 2
) (
  input  logic [ROB_WIDTH:0]           rf_q,
  input  logic [31:0]                  rf_v,
  input  logic                         rob_ready,
  input  logic [31:0]                  rob_v,
  input  logic [NUM_CDB-1:0]           cdb_en,
  input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]        cdb_value,
  output logic [ROB_WIDTH:0]           q,
  output logic [31:0]                  v
);
  localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

  always_comb begin
    q = rf_q;
    v = '0;
    if (rf_q == NON_DEP) begin
      v = rf_v;
    end else if (rob_ready) begin
      q = NON_DEP;
      v = rob_v;
    end else begin
      // Scanning downward lets the lowest-numbered matching channel win.
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_en[i] && (cdb_tag[i*ROB_WIDTH +: ROB_WIDTH] == rf_q[ROB_WIDTH-1:0])) begin
          q = NON_DEP;
          v = cdb_value[i*32 +: 32];
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue
// DEPTH-entry instruction FIFO between decoder and issue.
//   - Resolves the head's operands against RF, RoB and the CDB channels.
//   - Issues at most one instruction per cycle to either the reservation
//     station or the load/store buffer.
//   - On issue, allocates a RoB entry and renames the destination register.
// Optional build macro: DISPATCH_STALL_CNT_EN adds saturating stall counters.
// Ports:
//   Sys_clk      clock
//   Sys_rst      asynchronous active-high reset
//   Sys_rdy      global enable; low freezes state and masks every *_en pulse
//   bus          dispatch_queue_if.master (decoder, RF, RoB, CDB, RS, LSB buses)
//   dp_stall_rob/dp_stall_rs/dp_stall_lsb  stall counters (macro builds only)
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ROB_WIDTH  = 3,
  parameter int NUM_CDB    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic Sys_clk,
  input  logic Sys_rst,
  input  logic Sys_rdy,
  dispatch_queue_if.master bus
`ifdef DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0] dp_stall_rob,
  output logic [31:0] dp_stall_rs,
  output logic [31:0] dp_stall_lsb
`endif
);
  localparam int EX_ROB_WIDTH = ROB_WIDTH + 1;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam logic [EX_ROB_WIDTH-1:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [31:0]           imm;
    logic                  predict;
  } entry_t;

  typedef struct packed {
    logic                    rob_en;
    logic                    rf_en;
    logic                    rs_en;
    logic                    lsb_en;
    logic [5:0]              rf_rd;
    logic [ROB_WIDTH-1:0]    rf_rob_index;
    logic [ADDR_WIDTH-1:0]   rob_pc;
    logic [6:0]              rob_opcode;
    logic [5:0]              rob_rd;
    logic                    rob_predict;
    logic [ADDR_WIDTH-1:0]   rs_pc;
    logic [EX_ROB_WIDTH-1:0] rs_qj;
    logic [EX_ROB_WIDTH-1:0] rs_qk;
    logic [31:0]             rs_vj;
    logic [31:0]             rs_vk;
    logic [31:0]             rs_imm;
    logic [6:0]              rs_opcode;
    logic [ROB_WIDTH-1:0]    rs_rob_index;
    logic [EX_ROB_WIDTH-1:0] lsb_qj;
    logic [EX_ROB_WIDTH-1:0] lsb_qk;
    logic [31:0]             lsb_vj;
    logic [31:0]             lsb_vk;
    logic [31:0]             lsb_imm;
    logic [6:0]              lsb_opcode;
    logic [ROB_WIDTH-1:0]    lsb_rob_index;
  } out_t;

  localparam out_t OUT_RST = '{rs_qj: NON_DEP, rs_qk: NON_DEP,
                               lsb_qj: NON_DEP, lsb_qk: NON_DEP, default: '0};

  entry_t                  fifo_mem [DEPTH];
  logic [PTR_W-1:0]        head_ptr;
  logic [PTR_W-1:0]        tail_ptr;
  logic [CNT_W-1:0]        count_q;
  entry_t                  head;
  logic                    head_valid;
  logic                    head_is_ls;
  logic                    target_full;
  logic                    push;
  logic                    issue;
  logic [5:0]              rename_rd;
  logic [EX_ROB_WIDTH-1:0] qj;
  logic [EX_ROB_WIDTH-1:0] qk;
  logic [31:0]             vj;
  logic [31:0]             vk;
  out_t                    out_q;
  out_t                    out_d;

  assign head        = fifo_mem[head_ptr];
  assign head_valid  = (count_q != '0);
  assign head_is_ls  = (target_of(head.opcode) == TGT_LSB);
  assign target_full = head_is_ls ? bus.LSBDP_full : bus.RSDP_full;
  assign rename_rd   = writes_rd(head.opcode) ? {1'b0, head.rd} : NON_REG;

  // Ready looks only at the current count; a same-cycle pop does not free a slot early.
  assign bus.DCDP_ready = (count_q != CNT_W'(DEPTH));
  assign push  = bus.DCDP_valid && bus.DCDP_ready && Sys_rdy;
  assign issue = head_valid && !bus.RoBDP_full && !target_full && Sys_rdy;

  assign bus.DPRF_rs1 = (head_valid && has_rs1(head.opcode)) ? {1'b0, head.rs1} : NON_REG;
  assign bus.DPRF_rs2 = (head_valid && has_rs2(head.opcode)) ? {1'b0, head.rs2} : NON_REG;
  assign bus.DPRoB_Qj = bus.RFDP_Qj;
  assign bus.DPRoB_Qk = bus.RFDP_Qk;

  operand_resolver #(.ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)) u_resolve_j (
    .rf_q      (bus.RFDP_Qj),
    .rf_v      (bus.RFDP_Vj),
    .rob_ready (bus.RoBDP_Qj_ready),
    .rob_v     (bus.RoBDP_Vj),
    .cdb_en    (bus.CDBDP_en),
    .cdb_tag   (bus.CDBDP_RoB_index),
    .cdb_value (bus.CDBDP_value),
    .q         (qj),
    .v         (vj)
  );

  operand_resolver #(.ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)) u_resolve_k (
    .rf_q      (bus.RFDP_Qk),
    .rf_v      (bus.RFDP_Vk),
    .rob_ready (bus.RoBDP_Qk_ready),
    .rob_v     (bus.RoBDP_Vk),
    .cdb_en    (bus.CDBDP_en),
    .cdb_tag   (bus.CDBDP_RoB_index),
    .cdb_value (bus.CDBDP_value),
    .q         (qk),
    .v         (vk)
  );

  // Storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge Sys_clk) begin
    if (push) begin
      fifo_mem[tail_ptr] <= '{pc: bus.DCDP_pc, opcode: bus.DCDP_opcode, rs1: bus.DCDP_rs1,
                              rs2: bus.DCDP_rs2, rd: bus.DCDP_rd, imm: bus.DCDP_imm,
                              predict: bus.DCDP_predict};
    end
  end

  // Flush empties the queue even while Sys_rdy is low, mirroring reset.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (bus.RoBDP_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (issue) head_ptr <= head_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pulses last exactly one cycle; payloads hold until the next issue to the same target.
  always_comb begin
    out_d        = out_q;
    out_d.rob_en = issue;
    out_d.rf_en  = issue;
    out_d.rs_en  = issue && !head_is_ls;
    out_d.lsb_en = issue && head_is_ls;
    if (issue) begin
      out_d.rf_rd        = rename_rd;
      out_d.rf_rob_index = bus.RoBDP_RoB_index;
      out_d.rob_pc       = head.pc;
      out_d.rob_opcode   = head.opcode;
      out_d.rob_rd       = rename_rd;
      out_d.rob_predict  = head.predict;
      if (head_is_ls) begin
        out_d.lsb_qj        = qj;
        out_d.lsb_qk        = qk;
        out_d.lsb_vj        = vj;
        out_d.lsb_vk        = vk;
        out_d.lsb_imm       = head.imm;
        out_d.lsb_opcode    = head.opcode;
        out_d.lsb_rob_index = bus.RoBDP_RoB_index;
      end else begin
        out_d.rs_pc        = head.pc;
        out_d.rs_qj        = qj;
        out_d.rs_qk        = qk;
        out_d.rs_vj        = vj;
        out_d.rs_vk        = vk;
        out_d.rs_imm       = head.imm;
        out_d.rs_opcode    = head.opcode;
        out_d.rs_rob_index = bus.RoBDP_RoB_index;
      end
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      out_q <= OUT_RST;
    end else if (bus.RoBDP_flush) begin
      out_q <= OUT_RST;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.DPRoB_en        = out_q.rob_en & Sys_rdy;
  assign bus.DPRF_en         = out_q.rf_en & Sys_rdy;
  assign bus.DPRS_en         = out_q.rs_en & Sys_rdy;
  assign bus.DPLSB_en        = out_q.lsb_en & Sys_rdy;
  assign bus.DPRF_rd         = out_q.rf_rd;
  assign bus.DPRF_RoB_index  = out_q.rf_rob_index;
  assign bus.DPRoB_pc        = out_q.rob_pc;
  assign bus.DPRoB_opcode    = out_q.rob_opcode;
  assign bus.DPRoB_rd        = out_q.rob_rd;
  assign bus.DPRoB_predict   = out_q.rob_predict;
  assign bus.DPRS_pc         = out_q.rs_pc;
  assign bus.DPRS_Qj         = out_q.rs_qj;
  assign bus.DPRS_Qk         = out_q.rs_qk;
  assign bus.DPRS_Vj         = out_q.rs_vj;
  assign bus.DPRS_Vk         = out_q.rs_vk;
  assign bus.DPRS_imm        = out_q.rs_imm;
  assign bus.DPRS_opcode     = out_q.rs_opcode;
  assign bus.DPRS_RoB_index  = out_q.rs_rob_index;
  assign bus.DPLSB_Qj        = out_q.lsb_qj;
  assign bus.DPLSB_Qk        = out_q.lsb_qk;
  assign bus.DPLSB_Vj        = out_q.lsb_vj;
  assign bus.DPLSB_Vk        = out_q.lsb_vk;
  assign bus.DPLSB_imm       = out_q.lsb_imm;
  assign bus.DPLSB_opcode    = out_q.lsb_opcode;
  assign bus.DPLSB_RoB_index = out_q.lsb_rob_index;

`ifdef DISPATCH_STALL_CNT_EN
  // Counters survive flush; only Sys_rst clears them. They stick at all-ones.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      dp_stall_rob <= '0;
      dp_stall_rs  <= '0;
      dp_stall_lsb <= '0;
    end else if (Sys_rdy) begin
      if (head_valid && bus.RoBDP_full && (dp_stall_rob != '1))
        dp_stall_rob <= dp_stall_rob + 32'd1;
      if (head_valid && !head_is_ls && bus.RSDP_full && (dp_stall_rs != '1))
        dp_stall_rs <= dp_stall_rs + 32'd1;
      if (head_valid && head_is_ls && bus.LSBDP_full && (dp_stall_lsb != '1))
        dp_stall_lsb <= dp_stall_lsb + 32'd1;
    end
  end
`endif

endmodule
